// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HOLD sequencer with a one-entry output buffer to decode.
// Define DELAY_SLOT_EN for branch-delay-slot redirect semantics; the default is squash-on-redirect.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        flush_q, flush_d;
`ifdef DELAY_SLOT_EN
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
`endif

  logic [31:0] redir_tgt;
  logic        full_stalled;
  logic        ack_ok;

  always_comb begin
    redir_tgt    = {redir_pc[31:2], 2'b00};
    full_stalled = if_valid_q && stall;
    // The request drops in the same cycle the buffer is seen full and stalled,
    // so a full buffer can never be overrun by a second response.
    imem_req     = (state_q != IDLE) && !full_stalled;
    imem_addr    = pc_q;
    ack_ok       = imem_req && imem_ack;
  end

  // NOTE: every *_d gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    flush_d    = 1'b0;
`ifdef DELAY_SLOT_EN
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
`endif

    unique case (state_q)
      IDLE:    state_d = FETCH;
      default: state_d = full_stalled ? HOLD : FETCH;
    endcase

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

`ifdef DELAY_SLOT_EN
    if (ack_ok) begin
      if_valid_d   = 1'b1;
      if_instr_d   = imem_rdata;
      if_pc_d      = pc_q;
      pend_valid_d = 1'b0;
      // The acked word is the delay slot; a same-cycle redirect is the freshest target.
      if (redir_valid) begin
        pc_d = redir_tgt;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (redir_valid) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redir_tgt;
    end
`else
    if (redir_valid) begin
      pc_d       = redir_tgt;
      if_valid_d = 1'b0;
      flush_d    = 1'b1;
      state_d    = FETCH;
    end else if (ack_ok) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      flush_q    <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      flush_q    <= flush_d;
`ifdef DELAY_SLOT_EN
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
`endif
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl; inputs change on the falling edge, outputs
// are compared just after, i.e. the values decode and memory see before the next rising edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, imem_ack;
  logic [31:0] redir_pc, imem_rdata;
  logic        imem_req, if_valid, flush;
  logic [31:0] imem_addr, if_instr, if_pc;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc, ins;
    logic        fl;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I0 = 32'hA000_3000, I1 = 32'hA000_3004, I2 = 32'hDEAD_3008;
  localparam logic [31:0] I3 = 32'hB000_3040, I4 = 32'hC000_3040, I5 = 32'h5555_AAAA;
  localparam logic [31:0] LATE = 32'h9999_9999;

  function automatic vec_t mk(logic rst, logic st, logic rv, logic [31:0] rpc, logic ack,
                              logic [31:0] rdata, logic req, logic [31:0] addr, logic iv,
                              logic [31:0] ipc, logic [31:0] ins, logic fl);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ins = ins; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic ak, input logic [31:0] rd);
    @(negedge clk);
    reset = r; stall = st; redir_valid = rv; redir_pc = rpc; imem_ack = ak; imem_rdata = rd;
    #2;
  endtask

  task automatic check_outs(input int step, input logic req, input logic [31:0] addr,
                            input logic iv, input logic [31:0] ipc, input logic [31:0] ins,
                            input logic fl);
    check("imem_req", step, {31'b0, imem_req}, {31'b0, req});
    if (req) check("imem_addr", step, imem_addr, addr);
    check("if_valid", step, {31'b0, if_valid}, {31'b0, iv});
    check("if_pc", step, if_pc, ipc);
    check("if_instr", step, if_instr, ins);
    check("flush", step, {31'b0, flush}, {31'b0, fl});
  endtask

  initial begin
    // Straight-line fetch, then a 3-cycle stall with the buffer full.
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,   0,32'h3000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,   1,32'h3000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,1,I0,      1,32'h3000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,1,I1,      1,32'h3004,1,32'h3000,I0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0,   0,32'h3008,1,32'h3004,I1,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0,   0,32'h3008,1,32'h3004,I1,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0,   0,32'h3008,1,32'h3004,I1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,   1,32'h3008,1,32'h3004,I1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,   1,32'h3008,0,32'h3004,I1,0));
`ifdef DELAY_SLOT_EN
    // Redirect before the delay-slot ack, then an overwritten pending target.
    vecs.push_back(mk(0,0,1,32'h3043,0,32'h0, 1,32'h3008,0,32'h3004,I1,0));
    vecs.push_back(mk(0,0,0,32'h0,1,I2,       1,32'h3008,0,32'h3004,I1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3040,1,32'h3008,I2,0));
    vecs.push_back(mk(0,0,1,32'h3100,0,32'h0, 1,32'h3040,0,32'h3008,I2,0));
    vecs.push_back(mk(0,0,1,32'h3200,0,32'h0, 1,32'h3040,0,32'h3008,I2,0));
    vecs.push_back(mk(0,0,0,32'h0,1,I3,       1,32'h3040,0,32'h3008,I2,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3200,1,32'h3040,I3,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,    1,32'h3200,0,32'h3040,I3,0));
`else
    // Redirect colliding with an ack, redirect over stall, wrap-around, reset mid-request.
    vecs.push_back(mk(0,0,1,32'h3040,1,I2,    1,32'h3008,0,32'h3004,I1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3040,0,32'h3004,I1,1));
    vecs.push_back(mk(0,0,0,32'h0,1,I3,       1,32'h3040,0,32'h3004,I1,0));
    vecs.push_back(mk(0,1,1,32'h3043,0,32'h0, 0,32'h3044,1,32'h3040,I3,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0,    1,32'h3040,0,32'h3040,I3,1));
    vecs.push_back(mk(0,1,0,32'h0,1,I4,       1,32'h3040,0,32'h3040,I3,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3044,1,32'h3040,I4,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3044,0,32'h3040,I4,0));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,32'h0, 1,32'h3044,0,32'h3040,I4,0));
    vecs.push_back(mk(0,0,0,32'h0,1,I5,       1,32'hFFFF_FFFC,0,32'h3040,I4,1));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h0,1,32'hFFFF_FFFC,I5,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,    1,32'h0,0,32'hFFFF_FFFC,I5,0));
`endif
    vecs.push_back(mk(0,0,0,32'h0,1,LATE,     0,32'h3000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,    1,32'h3000,0,32'h0,32'h0,0));

    // Reset with a redirect pulse that must be ignored.
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0000_5000;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check_outs(-1, 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset_addr", -1, imem_addr, 32'h3000);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      check_outs(i, vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].ipc, vecs[i].ins, vecs[i].fl);
    end

    // Hand sequence: ack lands while decode is stalled, buffer must hold until release.
    drive(0, 1, 0, 32'h0, 1, 32'h1234_5678);
    check_outs(100, 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 32'h0, 1, 32'hBAD0_BAD0);
      check_outs(101 + k, 1'b0, 32'h3004, 1'b1, 32'h3000, 32'h1234_5678, 1'b0);
    end
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    check_outs(104, 1'b1, 32'h3004, 1'b1, 32'h3000, 32'h1234_5678, 1'b0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    check_outs(105, 1'b1, 32'h3004, 1'b0, 32'h3000, 32'h1234_5678, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
